// File: rtl/uart_tx_queue_pkg.sv
// Shared types for the UART transmit queue: launch sequencer state encoding.
package uart_tx_queue_pkg;

    // 2-bit launch sequencer states
    typedef enum logic [1:0] {
        TXQ_IDLE      = 2'd0,
        TXQ_LAUNCH    = 2'd1,
        TXQ_WAIT_ACK  = 2'd2,
        TXQ_WAIT_DONE = 2'd3
    } txq_state_e;

endpackage

// File: rtl/uart_tx_queue_sync_fifo.sv
// Synchronous circular-buffer FIFO with registered occupancy flags.
// A push while full is taken only when a pop lands in the same cycle;
// dout always shows the head entry (combinational read of the read slot).
module sync_fifo
    import uart_tx_queue_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic              r_full;
    logic              r_empty;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_pop  = pop && !r_empty;
    assign w_do_push = push && (!r_full || w_do_pop);

    // Next occupancy: a simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_next = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CNT_W'(DEPTH));
            r_empty <= (w_count_next == '0);
        end
    end

    // Storage array; a full-queue push overwrites the slot being popped this cycle
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue plus launch sequencer feeding a UART transmitter.
// Pops one byte into tx_data, pulses tx_activate, then waits for the
// transmitter's busy handshake (with an acknowledge timeout) before the next.
module uart_tx_queue
    import uart_tx_queue_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int DATA_W      = 8,
    parameter  int ACK_TIMEOUT = 255,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_flags,
    input  logic              tx_busy,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_activate,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              tx_error
);

    localparam int               TMR_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    txq_state_e        r_state;
    txq_state_e        w_state_next;
    logic [TMR_W-1:0]  r_timer;
    logic [DATA_W-1:0] r_tx_data;
    logic [DATA_W-1:0] w_fifo_dout;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_timer_clr;
    logic              w_timer_inc;
    logic              w_timeout;
    logic              w_ovf_event;
    logic              r_overflow;
    logic              r_tx_error;

    // A write into a full queue survives only if the sequencer pops in the same cycle
    assign w_push      = wr_en && (!w_fifo_full || w_pop);
    assign w_ovf_event = wr_en && w_fifo_full && !w_pop;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop),
        .din    (wr_data),
        .dout   (w_fifo_dout),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty),
        .count  (count)
    );

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= TXQ_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and control decode; IDLE also refuses to launch while a
    // frame left over from before a reset is still shifting out
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            TXQ_IDLE: begin
                if (!w_fifo_empty && !tx_busy) begin
                    w_pop        = 1'b1;
                    w_state_next = TXQ_LAUNCH;
                end
            end
            TXQ_LAUNCH: begin
                w_timer_clr  = 1'b1;
                w_state_next = TXQ_WAIT_ACK;
            end
            TXQ_WAIT_ACK: begin
                if (tx_busy) begin
                    w_state_next = TXQ_WAIT_DONE;
                end else if (r_timer == TMR_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = TXQ_IDLE;
                end else begin
                    w_timer_inc = 1'b1;
                end
            end
            TXQ_WAIT_DONE: begin
                if (!tx_busy) w_state_next = TXQ_IDLE;
            end
            default: w_state_next = TXQ_IDLE;
        endcase
    end

    // Acknowledge timer counts WAIT_ACK cycles without tx_busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset)            r_timer <= '0;
        else if (w_timer_clr) r_timer <= '0;
        else if (w_timer_inc) r_timer <= r_timer + TMR_W'(1);
    end

    // Output byte register changes only when the head is popped
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_tx_data <= '0;
        else if (w_pop) r_tx_data <= w_fifo_dout;
    end

    // Sticky flags; a same-cycle event beats clr_flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_tx_error <= 1'b0;
        end else begin
            r_overflow <= w_ovf_event || (r_overflow && !clr_flags);
            r_tx_error <= w_timeout   || (r_tx_error && !clr_flags);
        end
    end

    assign tx_activate = (r_state == TXQ_LAUNCH);
    assign tx_data     = r_tx_data;
    assign full        = w_fifo_full;
    assign empty       = w_fifo_empty;
    assign overflow    = r_overflow;
    assign tx_error    = r_tx_error;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: a queue-based reference model is
// compared against every output on every falling edge, and directed
// scenarios pin launch order, latency, overflow, timeout and reset behaviour.
module tb_uart_tx_queue;

    localparam int DEPTH       = 16;
    localparam int DATA_W      = 8;
    localparam int ACK_TIMEOUT = 255;
    localparam int CNT_W       = $clog2(DEPTH + 1);
    localparam int M_MANUAL    = 0;
    localparam int M_AUTO      = 1;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              wr_en     = 1'b0;
    logic [DATA_W-1:0] wr_data   = '0;
    logic              clr_flags = 1'b0;
    logic              tx_busy   = 1'b0;
    logic [DATA_W-1:0] tx_data;
    logic              tx_activate;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              tx_error;

    uart_tx_queue #(
        .DEPTH       (DEPTH),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .clr_flags   (clr_flags),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_activate (tx_activate),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .tx_error    (tx_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // transmitter responder
    int mode      = M_MANUAL;
    int resp_hold = 0;
    bit resp_arm  = 1'b0;
    int fall_cyc  = -100;

    // observed launches
    logic [DATA_W-1:0] act_q [$];
    int                act_cyc [$];

    // reference model: phase 0 idle, 1 pulsing, 2 awaiting busy, 3 awaiting done
    logic [DATA_W-1:0] mq [$];
    bit                m_ovf   = 1'b0;
    bit                m_err   = 1'b0;
    logic [DATA_W-1:0] m_txd   = '0;
    int                m_ph    = 0;
    int                m_wait  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Advance the model by one rising edge, using the inputs that edge sampled
    task automatic model_edge();
        int n;
        bit pop_now;
        bit wr_ok;
        bit ovf_ev;
        bit err_ev;
        n = mq.size(); pop_now = 0; wr_ok = 0; ovf_ev = 0; err_ev = 0;
        case (m_ph)
            0: if (n > 0 && !tx_busy) begin pop_now = 1; m_ph = 1; end
            1: begin m_wait = 0; m_ph = 2; end
            2: begin
                if (tx_busy) m_ph = 3;
                else begin
                    m_wait++;
                    if (m_wait >= ACK_TIMEOUT) begin err_ev = 1; m_ph = 0; end
                end
            end
            default: if (!tx_busy) m_ph = 0;
        endcase
        if (wr_en) begin
            if (n < DEPTH || pop_now) wr_ok = 1;
            else                      ovf_ev = 1;
        end
        if (pop_now) m_txd = mq.pop_front();
        if (wr_ok)   mq.push_back(wr_data);
        if (clr_flags) begin m_ovf = 0; m_err = 0; end
        if (ovf_ev) m_ovf = 1;
        if (err_ev) m_err = 1;
    endtask

    // One cycle: update model, compare all outputs, run the transmitter responder
    task automatic step();
        @(negedge clk);
        cyc++;
        if (reset) begin
            mq.delete(); m_ovf = 0; m_err = 0; m_txd = '0; m_ph = 0; m_wait = 0;
        end else begin
            model_edge();
            chk("count",       32'(count),       32'(mq.size()));
            chk("empty",       32'(empty),       32'(mq.size() == 0));
            chk("full",        32'(full),        32'(mq.size() == DEPTH));
            chk("overflow",    32'(overflow),    32'(m_ovf));
            chk("tx_error",    32'(tx_error),    32'(m_err));
            chk("tx_activate", 32'(tx_activate), 32'(m_ph == 1));
            chk("tx_data",     32'(tx_data),     32'(m_txd));
            if (tx_activate) begin
                chk("activate_while_busy", 32'(tx_busy), 32'(0));
                chk("activate_gap", 32'((cyc - fall_cyc) >= 2), 32'(1));
                act_q.push_back(tx_data);
                act_cyc.push_back(cyc);
            end
        end
        if (mode == M_AUTO) begin
            if (resp_hold > 0) begin
                resp_hold--;
                if (resp_hold == 0) begin tx_busy = 1'b0; fall_cyc = cyc; end
            end else if (resp_arm) begin
                tx_busy   = 1'b1;
                resp_hold = 10;
                resp_arm  = 1'b0;
            end
            if (tx_activate && !reset) resp_arm = 1'b1;
        end
    endtask

    task automatic wait_act(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (act_q.size() < target && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(act_q.size()), 32'(target));
    endtask

    initial begin
        int base;
        int a;
        int err_cyc;

        // reset values
        reset = 1'b1;
        step(); step();
        chk("rst_count",    32'(count),       32'(0));
        chk("rst_empty",    32'(empty),       32'(1));
        chk("rst_full",     32'(full),        32'(0));
        chk("rst_overflow", 32'(overflow),    32'(0));
        chk("rst_tx_error", 32'(tx_error),    32'(0));
        chk("rst_activate", 32'(tx_activate), 32'(0));
        chk("rst_tx_data",  32'(tx_data),     32'(0));
        reset = 1'b0;

        // single byte
        mode = M_AUTO;
        step(); wr_en = 1'b1; wr_data = 8'h07;
        step(); wr_en = 1'b0;
        wait_act(1, 20, "t1_wait_act");
        repeat (20) step();
        chk("t1_pulses",  32'(act_q.size()), 32'(1));
        chk("t1_data",    32'(act_q[0]),     32'h07);
        chk("t1_empty",   32'(empty),        32'(1));
        chk("t1_count",   32'(count),        32'(0));
        chk("t1_hold",    32'(tx_data),      32'h07);

        // burst of three
        base = act_q.size();
        step(); wr_en = 1'b1; wr_data = 8'h41;
        step(); wr_data = 8'h42;
        step(); wr_data = 8'h43;
        step(); wr_en = 1'b0;
        wait_act(base + 3, 100, "t2_wait_act");
        repeat (20) step();
        chk("t2_pulses", 32'(act_q.size()),   32'(base + 3));
        chk("t2_byte0",  32'(act_q[base]),     32'h41);
        chk("t2_byte1",  32'(act_q[base + 1]), 32'h42);
        chk("t2_byte2",  32'(act_q[base + 2]), 32'h43);

        // fill past capacity while the transmitter is busy
        mode = M_MANUAL;
        step(); tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h80 + i);
            step();
        end
        wr_en = 1'b0;
        step();
        chk("t3_count",    32'(count),    32'(16));
        chk("t3_full",     32'(full),     32'(1));
        chk("t3_overflow", 32'(overflow), 32'(1));
        clr_flags = 1'b1;
        step(); clr_flags = 1'b0;
        step();
        chk("t3_clr_overflow", 32'(overflow), 32'(0));
        chk("t3_count_kept",   32'(count),    32'(16));

        // write into a full queue on the cycle the sequencer pops
        base = act_q.size();
        wr_en = 1'b1; wr_data = 8'hA5; tx_busy = 1'b0; mode = M_AUTO;
        step(); wr_en = 1'b0;
        chk("t4_count",    32'(count),       32'(16));
        chk("t4_full",     32'(full),        32'(1));
        chk("t4_overflow", 32'(overflow),    32'(0));
        chk("t4_launch",   32'(tx_activate), 32'(1));
        wait_act(base + 17, 400, "t4_wait_drain");
        repeat (20) step();
        for (int i = 0; i < 16; i++)
            chk("t4_order", 32'(act_q[base + i]), 32'(8'h80 + i));
        chk("t4_last",  32'(act_q[base + 16]), 32'hA5);
        chk("t4_empty", 32'(empty),            32'(1));

        // acknowledge timeout
        base = act_q.size();
        mode = M_MANUAL;
        step(); wr_en = 1'b1; wr_data = 8'h55;
        step(); wr_data = 8'h66;
        step(); wr_en = 1'b0;
        wait_act(base + 1, 10, "t5_wait_act");
        a = act_cyc[base];
        chk("t5_data", 32'(act_q[base]), 32'h55);
        err_cyc = -1;
        for (int k = 0; k < 300 && err_cyc < 0; k++) begin
            step();
            if (tx_error) err_cyc = cyc;
        end
        chk("t5_timeout_delay", 32'(err_cyc - a), 32'(256));
        mode = M_AUTO;
        wait_act(base + 2, 10, "t5_next_launch");
        chk("t5_next_data",   32'(act_q[base + 1]),           32'h66);
        chk("t5_next_delay",  32'(act_cyc[base + 1] - err_cyc), 32'(1));
        chk("t5_err_sticky",  32'(tx_error),                   32'(1));
        repeat (20) step();
        clr_flags = 1'b1;
        step(); clr_flags = 1'b0;
        step();
        chk("t5_clr_err", 32'(tx_error), 32'(0));

        // reset while a frame is in flight with bytes queued
        base = act_q.size();
        mode = M_MANUAL;
        step(); wr_en = 1'b1; wr_data = 8'h11;
        step(); wr_en = 1'b0;
        wait_act(base + 1, 10, "t6_wait_act");
        step(); tx_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); wr_en = 1'b1; wr_data = 8'(8'h21 + i);
        end
        step(); wr_en = 1'b0;
        chk("t6_count_before", 32'(count), 32'(5));
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_count",    32'(count),       32'(0));
        chk("t6_rst_activate", 32'(tx_activate), 32'(0));
        chk("t6_rst_empty",    32'(empty),       32'(1));
        step(); step();
        reset = 1'b0;
        repeat (5) step();
        chk("t6_no_act_busy", 32'(act_q.size()), 32'(base + 1));
        tx_busy = 1'b0;
        repeat (5) step();
        chk("t6_no_act_idle", 32'(act_q.size()), 32'(base + 1));
        chk("t6_still_empty", 32'(empty),        32'(1));
        mode = M_AUTO;
        wr_en = 1'b1; wr_data = 8'h77;
        step(); wr_en = 1'b0;
        wait_act(base + 2, 10, "t6_wait_new");
        chk("t6_new_data", 32'(act_q[base + 1]), 32'h77);
        repeat (20) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_queue.md
Name: uart_tx_queue

Overview:
- Byte queue and launch sequencer directly upstream of uArtTx.
- Accepts bytes from the system side through a write strobe and buffers them in a FIFO.
- Presents one byte at a time on tx_data and pulses tx_activate, then waits for the transmitter's busy handshake to complete before launching the next byte.
- Lets software burst-write a message without tracking per-frame timing at any baudRate.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- DATA_W, 8, byte width; matches uArtTx data input.
- ACK_TIMEOUT, 255, max cycles to wait for tx_busy to rise after an activate pulse.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wr_en  in  1  push wr_data this cycle.
- wr_data  in  DATA_W  byte to queue.
- clr_flags  in  1  clears overflow and tx_error.
- tx_busy  in  1  high while uArtTx is shifting a frame.
- tx_data  out  DATA_W  byte presented to uArtTx; stable from the activate pulse until tx_busy falls.
- tx_activate  out  1  one-cycle launch pulse to uArtTx.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was dropped.
- tx_error  out  1  sticky: ACK_TIMEOUT expired.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and reset.
- Reset values:
  - tx_data = 0, tx_activate = 0, count = 0, empty = 1, full = 0, overflow = 0, tx_error = 0.
  - Pointers = 0, FSM = IDLE, timeout counter = 0.
- Reset mid-frame: the queue and FSM clear immediately. The frame already in uArtTx is not cancelled. After reset, the FSM stays in IDLE until tx_busy is low.
- FIFO:
  - Circular buffer; write/read pointers wrap modulo DEPTH.
  - full, empty and count are registered and consistent in the same cycle.
- Write:
  - wr_en with !full: stores the byte; count increments next cycle.
  - wr_en with full: no pop this cycle means the byte is dropped and overflow is set. A pop in the same cycle means the write is accepted and count is unchanged.
- Simultaneous push and pop on non-empty: count is unchanged and both pointers advance.
- Write to an empty queue: the byte is visible to the FSM on the next cycle (1-cycle fall-through latency minimum).
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
  - IDLE: if !empty and !tx_busy, pop the head into tx_data and go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_activate = 1 for exactly this cycle; clear the timeout counter; go to WAIT_ACK.
  - WAIT_ACK:
    - tx_busy = 1 → WAIT_DONE.
    - Otherwise increment the counter.
    - At ACK_TIMEOUT: set tx_error, discard the byte, go to IDLE.
  - WAIT_DONE: on tx_busy = 0 → IDLE. Holds indefinitely with no timeout.
- Minimum gap: IDLE→LAUNCH→…, so back-to-back frames have ≥1 idle cycle between tx_busy falling and the next activate pulse (activate occurs 2 cycles after tx_busy falls).
- tx_data changes only on a pop. It holds its last value otherwise.
- clr_flags: clears both sticky flags next cycle. If an overflow or timeout event occurs in the same cycle, the event wins and the flag stays set.
- Count width arithmetic: no saturation is needed beyond the full/empty guards. Pointers are $clog2(DEPTH) bits.

Decomposition:
- parameters.v: add FSM state encodings (`TXQ_IDLE, `TXQ_LAUNCH, `TXQ_WAIT_ACK, `TXQ_WAIT_DONE, 2-bit) alongside the existing baud-rate and parity codes.
- One sub-module, sync_fifo:
  - Parameterised by DEPTH/DATA_W.
  - Ports: push, pop, din, dout, full, empty, count.
- uart_tx_queue holds the FSM, timeout counter and sticky flags.

Test Plan:
- Reset, then write 0x07 once; a model raises tx_busy 1 cycle after activate and holds it 10 cycles → exactly one tx_activate pulse, tx_data = 0x07 during busy, empty = 1 afterwards, count returns to 0.
- Burst-write 0x41, 0x42, 0x43 on consecutive cycles → three activate pulses in order 0x41/0x42/0x43; each pulse ≥2 cycles after the previous tx_busy fall; never activate while tx_busy = 1.
- Write 17 bytes with tx_busy held high → count = 16, full = 1, 17th byte dropped, overflow = 1. Pulse clr_flags → overflow = 0.
- With full = 1, write on the same cycle the FSM pops → write accepted, count stays 16, overflow stays 0.
- Write 0x55 with tx_busy never rising → tx_error = 1 after 255 WAIT_ACK cycles, FSM back in IDLE, next queued byte launches normally.
- Assert reset while in WAIT_DONE with 5 bytes queued → count = 0, tx_activate = 0 immediately (asynchronous); no activate until tx_busy falls and a new write arrives.
